coin_dispense_arbiter: RTL

COIN_DISPENSE_ARBITER -- requirements
Module: coin_dispense_arbiter

---
 rtl/coin_dispense_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/coin_dispense_arbiter.sv
// Two-channel cola vending arbiter: per-channel coin credit, round-robin
// grant of a single shared dispenser, then change paid out in 0.5-yuan pulses.
module coin_dispense_arbiter #(
    parameter int PRICE    = 5,
    parameter int DISP_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ch0_half,
    input  logic ch1_half,
    input  logic ch0_one,
    input  logic ch1_one,
    output logic ch0_lock,
    output logic ch1_lock,
    output logic ch0_cola,
    output logic ch1_cola,
    output logic ch0_change,
    output logic ch1_change,
    output logic busy
);

    // Accepting stops at PRICE, so the worst case is PRICE-1 plus a 3-unit coin pair.
    localparam int CW    = $clog2(PRICE + 3);
    localparam int CNT_W = (DISP_CYC > 1) ? $clog2(DISP_CYC) : 1;

    localparam logic [CW-1:0]    PRICE_C  = CW'(PRICE);
    localparam logic [CW-1:0]    ONE_C    = CW'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DISP_CYC - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        CHANGE   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    credit0_q, credit0_d;
    logic [CW-1:0]    credit1_q, credit1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             grant_q, grant_d;
    logic             gnt_vld_q, gnt_vld_d;
    logic             rr_last_q, rr_last_d;

    logic          req0;
    logic          req1;
    logic          disp_last;
    logic [CW-1:0] gnt_credit;
    logic [CW-1:0] dec_amt;
    logic [CW-1:0] add0;
    logic [CW-1:0] add1;
    logic [CW-1:0] dec0;
    logic [CW-1:0] dec1;

    assign req0       = (credit0_q >= PRICE_C);
    assign req1       = (credit1_q >= PRICE_C);
    assign disp_last  = (state_q == DISPENSE) && (cnt_q == CNT_LAST);
    assign gnt_credit = grant_q ? credit1_q : credit0_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant is decided only from IDLE and stays fixed until the FSM returns there.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gnt_vld_d = gnt_vld_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d   = DISPENSE;
                    gnt_vld_d = 1'b1;
                    grant_d   = (req0 && req1) ? ~rr_last_q : req1;
                end
            end
            DISPENSE: begin
                if (disp_last) begin
                    if (gnt_credit != PRICE_C) begin
                        state_d = CHANGE;
                    end else begin
                        state_d   = IDLE;
                        gnt_vld_d = 1'b0;
                    end
                end
            end
            CHANGE: begin
                if (gnt_credit == ONE_C) begin
                    state_d   = IDLE;
                    gnt_vld_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                gnt_vld_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        cnt_d = '0;
        if ((state_q == DISPENSE) && !disp_last) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        rr_last_d = rr_last_q;
        if (disp_last) begin
            rr_last_d = grant_q;
        end

        dec_amt = '0;
        if (disp_last) begin
            dec_amt = PRICE_C;
        end else if (state_q == CHANGE) begin
            dec_amt = ONE_C;
        end

        add0 = ch0_lock ? '0 : CW'({ch0_one, ch0_half});
        add1 = ch1_lock ? '0 : CW'({ch1_one, ch1_half});
        dec0 = (gnt_vld_q && !grant_q) ? dec_amt : '0;
        dec1 = (gnt_vld_q &&  grant_q) ? dec_amt : '0;

        // The granted channel is locked, so a channel never gains and loses credit on one edge.
        credit0_d = credit0_q + add0 - dec0;
        credit1_d = credit1_q + add1 - dec1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit0_q <= '0;
            credit1_q <= '0;
            cnt_q     <= '0;
            grant_q   <= 1'b0;
            gnt_vld_q <= 1'b0;
            rr_last_q <= 1'b1;
        end else begin
            credit0_q <= credit0_d;
            credit1_q <= credit1_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            gnt_vld_q <= gnt_vld_d;
            rr_last_q <= rr_last_d;
        end
    end

    // All outputs decode registered state only; coin inputs never reach them directly.
    always_comb begin
        busy       = (state_q != IDLE);
        ch0_lock   = req0 || (gnt_vld_q && !grant_q);
        ch1_lock   = req1 || (gnt_vld_q &&  grant_q);
        ch0_cola   = disp_last && gnt_vld_q && !grant_q;
        ch1_cola   = disp_last && gnt_vld_q &&  grant_q;
        ch0_change = (state_q == CHANGE) && gnt_vld_q && !grant_q;
        ch1_change = (state_q == CHANGE) && gnt_vld_q &&  grant_q;
    end

endmodule
